arcade_keymap_multi: RTL and testbench

- Parametrised PS/2 keyboard-to-arcade-control mapper for up to four players, instantiated in the emu top level between hps_io and the game core.
- Decodes hps_io key-toggle events into registered per-player button state.
- Applies screen-rotation remapping to the directions and stretches coin presses to a guaranteed minimum width.
- Replaces the per-core inline casex decoders with one shared block.

---
 rtl/arcade_keymap_multi.sv | 230 +++++++++++++++++++++++
 tb/tb_arcade_keymap_multi.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_keymap_multi.sv
// arcade_keymap_multi
//   Shared PS/2 keyboard to arcade control mapper for 1..4 players. It sits
//   between hps_io and the game core. Key toggle events from hps_io update a
//   raw key-state table. Each player lane then applies screen rotation to the
//   directions and stretches coin presses. The result is registered, so a key
//   event appears on btn two clock edges after the toggle changes.
//
//   Optional feature: define ARCADE_KEYMAP_AUTOFIRE_EN to build per-player
//   autofire. Without it, the autofire port is accepted but ignored.
//
// Ports
//   clk_sys   system clock
//   reset     synchronous, active-high reset
//   ps2_key   [10] toggle, [9] pressed, [8] extended (E0), [7:0] scancode
//   rotate    0 none, 1 CW, 2 CCW, 3 180 degrees
//   autofire  per-player autofire enable
//   btn       player p owns btn[8p+7:8p]:
//             {coin, start, fire2, fire, up, down, left, right}
//   btn_test  service/test key

package arcade_keymap_pkg;
  // Raw key slots per player. Fire and start each have two physical keys.
  localparam logic [3:0] K_UP = 4'd0, K_DN = 4'd1, K_LT = 4'd2, K_RT = 4'd3,
                         K_FA = 4'd4, K_FB = 4'd5, K_F2 = 4'd6,
                         K_SA = 4'd7, K_SB = 4'd8, K_CN = 4'd9;
  localparam int NK = 10;
endpackage

// One player lane: raw key table, rotation, coin stretch, optional autofire,
// and the output register.
module arcade_keymap_player
  import arcade_keymap_pkg::*;
#(
  parameter logic [15:0] COIN_MIN  = 16'd50000,
  parameter int unsigned AF_PERIOD = 200000
)(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       key_wr,
  input  logic [3:0] key_sel,
  input  logic       key_dn,
  input  logic [1:0] rotate,
  input  logic       af_en,
  output logic [7:0] btn
);
  logic [NK-1:0] keys;
  logic          u, d, l, r, fire_raw, fire2, start, coin_raw, fire_nxt;
  logic [3:0]    dir;       // {up, down, left, right} after rotation
  logic          coin_d;
  logic [15:0]   coin_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset)       keys <= '0;
    else if (key_wr) keys[key_sel] <= key_dn;
  end

  assign u        = keys[K_UP];
  assign d        = keys[K_DN];
  assign l        = keys[K_LT];
  assign r        = keys[K_RT];
  assign fire_raw = keys[K_FA] | keys[K_FB];
  assign fire2    = keys[K_F2];
  assign start    = keys[K_SA] | keys[K_SB];
  assign coin_raw = keys[K_CN];

  always_comb begin
    dir = {u, d, l, r};
    case (rotate)
      2'd1:    dir = {l, r, d, u};  // CW: U->right, R->down, D->left, L->up
      2'd2:    dir = {r, l, u, d};  // CCW: U->left, L->down, D->right, R->up
      2'd3:    dir = {d, u, r, l};  // 180
      default: ;
    endcase
  end

`ifdef ARCADE_KEYMAP_AUTOFIRE_EN
  logic        af_act, af_run;
  logic [31:0] af_cnt;

  assign af_act = fire_raw & af_en;

  // The first active cycle forces fire high and loads a full half-period.
  // After that, fire flips each time the phase counter runs out.
  always_comb begin
    fire_nxt = fire_raw;
    if (af_act) begin
      if (!af_run)            fire_nxt = 1'b1;
      else if (af_cnt == '0)  fire_nxt = ~btn[4];
      else                    fire_nxt = btn[4];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_run <= 1'b0;
      af_cnt <= '0;
    end else begin
      af_run <= af_act;
      if (!af_run || af_cnt == '0) af_cnt <= AF_PERIOD - 1;
      else                         af_cnt <= af_cnt - 32'd1;
    end
  end
`else
  logic unused_af;
  assign unused_af = af_en;
  assign fire_nxt  = fire_raw;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn      <= '0;
      coin_d   <= 1'b0;
      coin_cnt <= '0;
    end else begin
      coin_d <= coin_raw;
      // A fresh press always reloads, even in the middle of a stretch.
      if (coin_raw && !coin_d)  coin_cnt <= COIN_MIN - 16'd1;
      else if (coin_cnt != '0)  coin_cnt <= coin_cnt - 16'd1;
      btn <= {coin_raw | (coin_cnt != '0), start, fire2, fire_nxt, dir};
    end
  end
endmodule

module arcade_keymap_multi
  import arcade_keymap_pkg::*;
#(
  parameter int unsigned PLAYERS   = 2,
  parameter logic [15:0] COIN_MIN  = 16'd50000,
  parameter int unsigned AF_PERIOD = 200000
)(
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic [1:0]           rotate,
  input  logic [PLAYERS-1:0]   autofire,
  output logic [8*PLAYERS-1:0] btn,
  output logic                 btn_test
);
  // Non-extended arrow-pad codes belong to P4 only in a four-player build.
  // In smaller builds they are a second set of P1 directions.
  localparam logic [1:0] P_NUMPAD = (PLAYERS == 4) ? 2'd3 : 2'd0;

  logic       old_tog, evt;
  logic       hit, hit_test;
  logic [1:0] hit_p;
  logic [3:0] hit_k;
  logic       raw_test;

  assign evt = ps2_key[10] != old_tog;

  always_comb begin
    hit      = 1'b1;
    hit_test = 1'b0;
    hit_p    = 2'd0;
    hit_k    = K_UP;
    case ({ps2_key[8], ps2_key[7:0]})
      // P1
      9'h175: hit_k = K_UP;
      9'h172: hit_k = K_DN;
      9'h16B: hit_k = K_LT;
      9'h174: hit_k = K_RT;
      9'h075: begin hit_p = P_NUMPAD; hit_k = K_UP; end
      9'h072: begin hit_p = P_NUMPAD; hit_k = K_DN; end
      9'h06B: begin hit_p = P_NUMPAD; hit_k = K_LT; end
      9'h074: begin hit_p = P_NUMPAD; hit_k = K_RT; end
      9'h029: hit_k = K_FA;
      9'h014: hit_k = K_FB;
      9'h011: hit_k = K_F2;
      9'h005: hit_k = K_SA;
      9'h016: hit_k = K_SB;
      9'h02E: hit_k = K_CN;
      // P2
      9'h02D: begin hit_p = 2'd1; hit_k = K_UP; end
      9'h02B: begin hit_p = 2'd1; hit_k = K_DN; end
      9'h023: begin hit_p = 2'd1; hit_k = K_LT; end
      9'h034: begin hit_p = 2'd1; hit_k = K_RT; end
      9'h01C: begin hit_p = 2'd1; hit_k = K_FA; end
      9'h01B: begin hit_p = 2'd1; hit_k = K_F2; end
      9'h006: begin hit_p = 2'd1; hit_k = K_SA; end
      9'h01E: begin hit_p = 2'd1; hit_k = K_SB; end
      9'h036: begin hit_p = 2'd1; hit_k = K_CN; end
      // P3
      9'h043: begin hit_p = 2'd2; hit_k = K_UP; end
      9'h042: begin hit_p = 2'd2; hit_k = K_DN; end
      9'h03B: begin hit_p = 2'd2; hit_k = K_LT; end
      9'h04B: begin hit_p = 2'd2; hit_k = K_RT; end
      9'h114: begin hit_p = 2'd2; hit_k = K_FA; end
      9'h111: begin hit_p = 2'd2; hit_k = K_F2; end
      9'h026: begin hit_p = 2'd2; hit_k = K_SA; end
      9'h03D: begin hit_p = 2'd2; hit_k = K_CN; end
      // P4 (directions share the numpad codes above)
      9'h070: begin hit_p = 2'd3; hit_k = K_FA; end
      9'h071: begin hit_p = 2'd3; hit_k = K_F2; end
      9'h025: begin hit_p = 2'd3; hit_k = K_SA; end
      9'h03E: begin hit_p = 2'd3; hit_k = K_CN; end
      9'h02C: begin hit = 1'b0; hit_test = 1'b1; end
      default: hit = 1'b0;
    endcase
  end

  // old_tog follows the toggle through reset, so the first cycle after
  // reset never sees a stale event.
  always_ff @(posedge clk_sys) begin
    old_tog <= ps2_key[10];
    if (reset) begin
      raw_test <= 1'b0;
      btn_test <= 1'b0;
    end else begin
      if (evt && hit_test) raw_test <= ps2_key[9];
      btn_test <= raw_test;
    end
  end

  // Codes for players at or above PLAYERS have no lane, so they are dropped.
  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    arcade_keymap_player #(
      .COIN_MIN (COIN_MIN),
      .AF_PERIOD(AF_PERIOD)
    ) u_pl (
      .clk_sys(clk_sys),
      .reset  (reset),
      .key_wr (evt && hit && (hit_p == 2'(p))),
      .key_sel(hit_k),
      .key_dn (ps2_key[9]),
      .rotate (rotate),
      .af_en  (autofire[p]),
      .btn    (btn[8*p +: 8])
    );
  end
endmodule

// File: tb/tb_arcade_keymap_multi.sv
module tb_arcade_keymap_multi;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [1:0]  rotate;
  logic [1:0]  autofire2;
  logic [3:0]  autofire4;
  logic [15:0] btn2;
  logic [31:0] btn4;
  logic        test2, test4;
  logic        tog;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_keymap_multi #(.PLAYERS(2), .COIN_MIN(16'd20), .AF_PERIOD(4)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .rotate(rotate),
    .autofire(autofire2), .btn(btn2), .btn_test(test2));

  arcade_keymap_multi #(.PLAYERS(4), .COIN_MIN(16'd20), .AF_PERIOD(4)) dut4 (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .rotate(rotate),
    .autofire(autofire4), .btn(btn4), .btn_test(test4));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic send_key(input logic dn, input logic ext, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, dn, ext, code};
  endtask

  task automatic test_reset;
    int bad_cyc;
    reset = 1'b1;
    step(3);
    n_cmp++;
    if (btn2 !== 16'h0 || test2 !== 1'b0) begin
      n_bad++; $display("FAIL reset_p2 btn=%h test=%b exp 0", btn2, test2);
    end
    n_cmp++;
    if (btn4 !== 32'h0 || test4 !== 1'b0) begin
      n_bad++; $display("FAIL reset_p4 btn=%h test=%b exp 0", btn4, test4);
    end
    reset   = 1'b0;
    bad_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (btn2 !== 16'h0 || btn4 !== 32'h0) bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc !== 0) begin
      n_bad++; $display("FAIL post_reset_idle nonzero_cycles=%0d exp 0", bad_cyc);
    end
  endtask

  task automatic test_latency;
    rotate = 2'd0;
    send_key(1'b1, 1'b1, 8'h75);
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0) begin
      n_bad++; $display("FAIL lat_press_edge1 btn=%h exp 0000", btn2);
    end
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0008) begin
      n_bad++; $display("FAIL lat_press_edge2 btn=%h exp 0008", btn2);
    end
    n_cmp++;
    if (btn4 !== 32'h8) begin
      n_bad++; $display("FAIL lat_p4_ext_up btn=%h exp 00000008", btn4);
    end
    send_key(1'b0, 1'b1, 8'h75);
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0008) begin
      n_bad++; $display("FAIL lat_rel_edge1 btn=%h exp 0008", btn2);
    end
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0) begin
      n_bad++; $display("FAIL lat_rel_edge2 btn=%h exp 0000", btn2);
    end
  endtask

  task automatic test_rotate;
    rotate = 2'd1;
    send_key(1'b1, 1'b0, 8'h2D);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0100) begin
      n_bad++; $display("FAIL rot_cw_p2up btn=%h exp 0100", btn2);
    end
    rotate = 2'd3;
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0400) begin
      n_bad++; $display("FAIL rot_180_p2up btn=%h exp 0400", btn2);
    end
    send_key(1'b0, 1'b0, 8'h2D);
    step(2);
    rotate = 2'd2;
    send_key(1'b1, 1'b1, 8'h74);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0008) begin
      n_bad++; $display("FAIL rot_ccw_p1right btn=%h exp 0008", btn2);
    end
    send_key(1'b0, 1'b1, 8'h74);
    step(2);
    rotate = 2'd0;
    send_key(1'b1, 1'b1, 8'h75);
    step(1);
    send_key(1'b1, 1'b1, 8'h72);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h000C) begin
      n_bad++; $display("FAIL rot_opposing_0 btn=%h exp 000c", btn2);
    end
    rotate = 2'd1;
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0003) begin
      n_bad++; $display("FAIL rot_opposing_cw btn=%h exp 0003", btn2);
    end
    send_key(1'b0, 1'b1, 8'h75);
    step(1);
    send_key(1'b0, 1'b1, 8'h72);
    step(2);
    rotate = 2'd0;
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0) begin
      n_bad++; $display("FAIL rot_released btn=%h exp 0000", btn2);
    end
  endtask

  task automatic test_coin;
    int hi, first, last, lows;
    // short press: 3 raw cycles, stretched to 20 output cycles
    hi = 0; first = 0; last = 0;
    send_key(1'b1, 1'b0, 8'h2E);
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (btn2[7]) begin
        hi++;
        if (first == 0) first = i;
        last = i;
      end
      if (i == 3) send_key(1'b0, 1'b0, 8'h2E);
    end
    n_cmp++;
    if (hi !== 20) begin
      n_bad++; $display("FAIL coin_short_width got=%0d exp 20", hi);
    end
    n_cmp++;
    if (first !== 2 || last !== 21) begin
      n_bad++; $display("FAIL coin_short_span got=%0d..%0d exp 2..21", first, last);
    end
    // long hold: follows the key, drops 2 edges after release
    send_key(1'b1, 1'b0, 8'h2E);
    step(2);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      if (!btn2[7]) lows++;
      step(1);
    end
    n_cmp++;
    if (lows !== 0) begin
      n_bad++; $display("FAIL coin_hold low_cycles=%0d exp 0", lows);
    end
    send_key(1'b0, 1'b0, 8'h2E);
    step(1);
    n_cmp++;
    if (btn2[7] !== 1'b1) begin
      n_bad++; $display("FAIL coin_rel_edge1 coin=%b exp 1", btn2[7]);
    end
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0) begin
      n_bad++; $display("FAIL coin_rel_edge2 btn=%h exp 0000", btn2);
    end
    // second press inside the stretch reloads the counter
    hi = 0; first = 0; last = 0;
    send_key(1'b1, 1'b0, 8'h2E);
    for (int i = 1; i <= 45; i++) begin
      step(1);
      if (btn2[7]) begin
        hi++;
        if (first == 0) first = i;
        last = i;
      end
      if (i == 3)  send_key(1'b0, 1'b0, 8'h2E);
      if (i == 10) send_key(1'b1, 1'b0, 8'h2E);
      if (i == 11) send_key(1'b0, 1'b0, 8'h2E);
    end
    n_cmp++;
    if (hi !== 30 || first !== 2 || last !== 31) begin
      n_bad++; $display("FAIL coin_reload got=%0d cycles %0d..%0d exp 30 cycles 2..31", hi, first, last);
    end
  endtask

  task automatic test_mapping;
    send_key(1'b1, 1'b0, 8'h05);
    step(1);
    send_key(1'b1, 1'b0, 8'h16);
    step(1);
    send_key(1'b0, 1'b0, 8'h05);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0040) begin
      n_bad++; $display("FAIL map_start_or btn=%h exp 0040", btn2);
    end
    send_key(1'b0, 1'b0, 8'h16);
    step(1);
    send_key(1'b1, 1'b0, 8'h1C);
    step(1);
    send_key(1'b1, 1'b0, 8'h1C);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h1000) begin
      n_bad++; $display("FAIL map_p2_fire btn=%h exp 1000", btn2);
    end
    send_key(1'b0, 1'b0, 8'h1C);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0) begin
      n_bad++; $display("FAIL map_idempotent_rel btn=%h exp 0000", btn2);
    end
    send_key(1'b1, 1'b0, 8'h11);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0020) begin
      n_bad++; $display("FAIL map_p1_fire2 btn=%h exp 0020", btn2);
    end
    send_key(1'b0, 1'b0, 8'h11);
    step(2);
  endtask

  task automatic test_players;
    send_key(1'b1, 1'b0, 8'h75);
    step(2);
    n_cmp++;
    if (btn4 !== 32'h0800_0000) begin
      n_bad++; $display("FAIL p4_numpad_up btn=%h exp 08000000", btn4);
    end
    send_key(1'b0, 1'b0, 8'h75);
    step(2);
    send_key(1'b1, 1'b0, 8'h70);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0 || btn4 !== 32'h1000_0000) begin
      n_bad++; $display("FAIL p4_fire btn2=%h btn4=%h exp 0000 10000000", btn2, btn4);
    end
    send_key(1'b0, 1'b0, 8'h70);
    step(1);
    send_key(1'b1, 1'b0, 8'h43);
    step(2);
    n_cmp++;
    if (btn2 !== 16'h0 || btn4 !== 32'h0008_0000) begin
      n_bad++; $display("FAIL p3_up btn2=%h btn4=%h exp 0000 00080000", btn2, btn4);
    end
    send_key(1'b0, 1'b0, 8'h43);
    step(1);
    send_key(1'b1, 1'b0, 8'h2C);
    step(2);
    n_cmp++;
    if (test2 !== 1'b1 || test4 !== 1'b1 || btn2 !== 16'h0) begin
      n_bad++; $display("FAIL test_key t2=%b t4=%b btn2=%h exp 1 1 0000", test2, test4, btn2);
    end
    send_key(1'b0, 1'b0, 8'h2C);
    step(2);
    n_cmp++;
    if (test2 !== 1'b0 || btn4 !== 32'h0) begin
      n_bad++; $display("FAIL test_key_rel t2=%b btn4=%h exp 0 00000000", test2, btn4);
    end
  endtask

  task automatic test_back_to_back;
    send_key(1'b1, 1'b0, 8'h23);
    step(1);
    send_key(1'b1, 1'b0, 8'h34);
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0200) begin
      n_bad++; $display("FAIL b2b_1 btn=%h exp 0200", btn2);
    end
    send_key(1'b0, 1'b0, 8'h23);
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0300) begin
      n_bad++; $display("FAIL b2b_2 btn=%h exp 0300", btn2);
    end
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0100) begin
      n_bad++; $display("FAIL b2b_3 btn=%h exp 0100", btn2);
    end
    send_key(1'b0, 1'b0, 8'h34);
    step(2);
  endtask

  task automatic test_autofire;
    logic exp_f;
    int   bad_f;
    autofire2 = 2'b01;
    send_key(1'b1, 1'b0, 8'h29);
    step(1);
    n_cmp++;
    if (btn2[4] !== 1'b0) begin
      n_bad++; $display("FAIL af_edge1 fire=%b exp 0", btn2[4]);
    end
    bad_f = 0;
    for (int i = 2; i <= 13; i++) begin
      step(1);
`ifdef ARCADE_KEYMAP_AUTOFIRE_EN
      exp_f = (((i - 2) / 4) % 2) == 0;
`else
      exp_f = 1'b1;
`endif
      if (btn2[4] !== exp_f) bad_f++;
    end
    n_cmp++;
    if (bad_f !== 0) begin
      n_bad++; $display("FAIL af_pattern wrong_cycles=%0d exp 0", bad_f);
    end
    step(1);
    reset = 1'b1;
    step(1);
    n_cmp++;
    if (btn2 !== 16'h0) begin
      n_bad++; $display("FAIL af_reset_abort btn=%h exp 0000", btn2);
    end
    reset = 1'b0;
    step(3);
    n_cmp++;
    if (btn2 !== 16'h0 || btn4 !== 32'h0) begin
      n_bad++; $display("FAIL af_after_reset btn2=%h btn4=%h exp 0", btn2, btn4);
    end
    autofire2 = 2'b00;
  endtask

  initial begin
    tog       = 1'b1;
    ps2_key   = 11'h400;
    reset     = 1'b1;
    rotate    = 2'd0;
    autofire2 = 2'b00;
    autofire4 = 4'b0000;
    test_reset();
    test_latency();
    test_rotate();
    test_coin();
    test_mapping();
    test_players();
    test_back_to_back();
    test_autofire();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
